fetch_stage: RTL

Instruction-fetch stage of the 8-bit MIPS core. Owns the program counter and drives the fetch address to the instruction memory. Captures the combinationally returned instruction into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect, PC wrap and a HALT opcode, and keeps a saturating fetch counter for performance.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the memory-returned instruction into IF/ID,
// 1-cycle latency; stall holds PC and IF/ID, flush squashes IF/ID, redirect beats both.
module fetch_stage #(
    parameter int              PC_W        = 8,
    parameter int              INSTR_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC    = 8'h00,
    parameter logic [PC_W-1:0] PC_LIMIT    = 8'hFF,
    parameter bit              HALT_EN     = 1'b1,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc_op,
    input  logic [INSTR_W-1:0] im_out,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus1,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic [PC_W-1:0]    ipc1_q, ipc1_d;
    logic [15:0]        count_q, count_d;
    logic [PC_W-1:0]    pc_seq;

    assign pc_seq = (pc_q == PC_LIMIT) ? '0 : pc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc1_d  = ipc1_q;
        count_d = count_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (flush) begin
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = im_out;
                    ipc_d   = pc_q;
                    ipc1_d  = pc_seq;
                    valid_d = 1'b1;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    // HALT is captured but the PC parks on its address
                    if (HALT_EN && (im_out == HALT_OPCODE)) state_d = S_HALT;
                    else                                    pc_d    = pc_seq;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = S_RUN;
                end else if (flush || !stall) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            ipc1_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc1_q  <= ipc1_d;
            count_q <= count_d;
        end
    end

    assign pc_op         = pc_q;
    assign ifid_valid    = valid_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc       = ipc_q;
    assign ifid_pc_plus1 = ipc1_q;
    assign halted        = (state_q == S_HALT);
    assign fetch_count   = count_q;

endmodule
